// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, ALU opcode
// values, the halt word and instruction-word field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPER, EXEC, HALT} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam logic [15:0] HLT_WORD = 16'hFFFF;

  // ir[15] mode, ir[14:12] opcode, ir[11:0] address
  localparam int MODE_BIT = 15;
  localparam int OPC_HI   = 14;
  localparam int OPC_LO   = 12;

  function automatic logic is_mem_ref(input logic [15:0] ir);
    return ~ir[MODE_BIT];
  endfunction

endpackage

// File: rtl/alu_seq_memif.sv
// Memory request holder for the ALU sequencer. mem_req/mem_addr are
// registered from the FSM's next-state view, so they are glitch-free and drop
// asynchronously with reset.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN -- watchdog that flags a
// request left without ack for TIMEOUT_CYCLES cycles.
// Ports: clk, rst_n; req_d/addr_d (next request from FSM); mem_ack in;
//        mem_req/mem_addr out; ack_ok (ack while requesting); timeout; err.
module alu_seq_memif #(
  parameter int ADDR_W = 12
`ifdef ALU_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ack_ok,
  output logic              timeout,
  output logic              err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_req <= req_d;
      if (req_d) mem_addr <= addr_d;
    end
  end

  // acks outside an outstanding request are ignored
  assign ack_ok = mem_req & mem_ack;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  // fires in the TIMEOUT_CYCLES-th unacked request cycle
  assign timeout = mem_req && !mem_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | timeout;
      if (mem_req && !mem_ack && !timeout) cnt <= cnt + CW'(1);
      else                                 cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Control-side initiator for the 16-bit bus ALU: fetches instructions,
// fetches memory operands, drives the ALU and captures AC/E/PC updates.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN (memory-ack watchdog, err out).
// Ports: clk/rst_n; start pulse; mem_req/mem_addr/mem_rdata/mem_ack read
//        handshake; alu_a/alu_b/alu_opcode/alu_ei to ALU; alu_out/alu_eo/
//        alu_inc from ALU; pc/ac/e_flag architectural state; busy/halted/err.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  output logic              alu_ei,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_eo,
  input  logic              alu_inc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              e_flag,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d, ac_q, ac_d, opnd_q, opnd_d;
  logic              e_q, e_d, req_d, ack_ok, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= ADDR_W'(RESET_PC);
      ir_q   <= '0;
      ac_q   <= '0;
      opnd_q <= '0;
      e_q    <= 1'b0;
    end else begin
      state  <= state_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      ac_q   <= ac_d;
      opnd_q <= opnd_d;
      e_q    <= e_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    opnd_d  = opnd_q;
    e_d     = e_q;
    case (state)
      IDLE, HALT: if (start) state_d = FETCH;
      FETCH: begin
        if (timeout) state_d = HALT;
        else if (ack_ok) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (ir_q == HLT_WORD)    state_d = HALT;
        else if (is_mem_ref(ir_q)) state_d = OPER;
        else begin
          opnd_d  = '0;
          state_d = EXEC;
        end
      end
      OPER: begin
        if (timeout) state_d = HALT;
        else if (ack_ok) begin
          opnd_d  = mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        ac_d = alu_out;
        e_d  = alu_eo;
        if (alu_inc) pc_d = pc_q + ADDR_W'(1);  // skip wraps like a normal increment
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    // request is registered from the next state so it is up in the first
    // FETCH/OPER cycle and down the cycle after the ack
    req_d  = (state_d == FETCH) || (state_d == OPER);
    addr_d = (state_d == FETCH) ? pc_d : ir_d[ADDR_W-1:0];
  end

  alu_seq_memif #(
    .ADDR_W(ADDR_W)
`ifdef ALU_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_memif (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_d   (req_d),
    .addr_d  (addr_d),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .ack_ok  (ack_ok),
    .timeout (timeout),
    .err     (err)
  );

`ifndef ALU_SEQ_TIMEOUT_EN
  // watchdog limit has no effect without the watchdog
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign alu_a      = ac_q;
  assign alu_b      = opnd_q;
  assign alu_opcode = ir_q[OPC_HI:OPC_LO];
  assign alu_ei     = e_q;
  assign pc         = pc_q;
  assign ac         = ac_q;
  assign e_flag     = e_q;
  assign busy       = (state != IDLE) && (state != HALT);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: bench-side memory and ALU models,
// a scoreboard of expected {fetch address, AC, E} per instruction fetch,
// a table-driven program plus hand-written corner-case sequences.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk, rst_n, start;
  logic          mem_req, mem_ack;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_rdata, alu_a, alu_b, alu_out, ac;
  logic [2:0]    alu_opcode;
  logic          alu_ei, alu_eo, alu_inc, e_flag, busy, halted, err;

  logic [DW-1:0] mem [0:4095];
  logic          skip_en;
  logic [AW-1:0] skip_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] ac;
    logic          e;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] opnd;
    logic [DW-1:0] ac;
    logic          e;
  } vec_t;
  vec_t vt[11];

  alu_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ei(alu_ei),
    .alu_out(alu_out), .alu_eo(alu_eo), .alu_inc(alu_inc),
    .pc(pc), .ac(ac), .e_flag(e_flag), .busy(busy), .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: arithmetic E-out is carry/borrow, logic ops pass E through
  always_comb begin
    logic [DW:0] t;
    t       = '0;
    alu_out = '0;
    alu_eo  = alu_ei;
    case (alu_opcode)
      OP_ADD: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = t[DW-1:0]; alu_eo = t[DW]; end
      OP_SUB: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = t[DW-1:0]; alu_eo = t[DW]; end
      OP_INC: begin t = {1'b0, alu_a} + 17'd1;         alu_out = t[DW-1:0]; alu_eo = t[DW]; end
      OP_DEC: begin t = {1'b0, alu_a} - 17'd1;         alu_out = t[DW-1:0]; alu_eo = t[DW]; end
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = ~alu_a;
    endcase
    alu_inc = skip_en && (pc == skip_pc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_pc"},       32'(pc),       32'd0);
    chk({tag, "_ac"},       32'(ac),       32'd0);
    chk({tag, "_e"},        32'(e_flag),   32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_halted"},   32'(halted),   32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1 check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clear_mem(input logic [DW-1:0] fill);
    for (int i = 0; i < 4096; i++) mem[i] = fill;
  endtask

  task automatic push_exp(input int addr, input logic [DW-1:0] a, input logic e);
    exp_t x;
    x.addr = AW'(addr);
    x.ac   = a;
    x.e    = e;
    sb.push_back(x);
  endtask

  // Serves memory requests until every expected fetch has been seen.
  // Called at a negedge; ack wait per request is (request index % wt_mod).
  task automatic run_prog(input int wt_mod);
    bit            want_oper = 1'b0;
    logic [AW-1:0] oaddr = '0;
    logic [DW-1:0] data;
    int            nreq = 0;
    int            budget;
    exp_t          x;
    while (sb.size() > 0) begin
      budget = 50;
      while (!mem_req && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!mem_req) begin
        chk("req_wait_expired", 32'(mem_req), 32'd1);
        sb.delete();
        return;
      end
      if (want_oper) begin
        chk("oper_addr", 32'(mem_addr), 32'(oaddr));
        data      = mem[mem_addr];
        want_oper = 1'b0;
      end else begin
        x = sb.pop_front();
        chk("fetch_addr", 32'(mem_addr), 32'(x.addr));
        chk("fetch_ac",   32'(ac),       32'(x.ac));
        chk("fetch_e",    32'(e_flag),   32'(x.e));
        data = mem[mem_addr];
        if (!data[15]) begin
          want_oper = 1'b1;
          oaddr     = data[AW-1:0];
        end
      end
      for (int w = 0; w < nreq % wt_mod; w++) @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack = 1'b0;
      nreq++;
    end
  endtask

  task automatic wait_halted(input string tag);
    int budget = 20;
    while (!halted && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  initial begin
    logic [DW-1:0] pac;
    logic          pe;
    rst_n = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    skip_en = 1'b0; skip_pc = '0;
    clear_mem('0);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // ADD @5 with mem[5]=3, then HLT; then resume from HALT
    mem[0] = 16'h0005; mem[5] = 16'h0003; mem[1] = 16'hFFFF;
    push_exp(0, 16'h0000, 1'b0);
    push_exp(1, 16'h0003, 1'b0);
    pulse_start();
    chk("add_busy", 32'(busy), 32'd1);
    run_prog(2);
    wait_halted("add");
    chk("add_pc", 32'(pc), 32'd2);
    chk("add_ac", 32'(ac), 32'h3);
    mem[2] = 16'hA000; mem[3] = 16'hFFFF;
    push_exp(2, 16'h0003, 1'b0);
    push_exp(3, 16'h0004, 1'b0);
    pulse_start();
    run_prog(1);
    wait_halted("resume");
    chk("resume_pc", 32'(pc), 32'd4);
    chk("resume_ac", 32'(ac), 32'h4);

    // INC x3 then HLT
    apply_reset("rst2");
    clear_mem('0);
    for (int i = 0; i < 3; i++) mem[i] = 16'hA000;
    mem[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) push_exp(i, DW'(i), 1'b0);
    pulse_start();
    run_prog(1);
    wait_halted("inc3");
    chk("inc3_pc", 32'(pc), 32'd4);
    chk("inc3_ac", 32'(ac), 32'd3);

    // table-driven program covering every opcode, both modes, E changes
    vt[0]  = '{16'hA000, 16'h0000, 16'h0001, 1'b0};
    vt[1]  = '{16'hA000, 16'h0000, 16'h0002, 1'b0};
    vt[2]  = '{16'hA000, 16'h0000, 16'h0003, 1'b0};
    vt[3]  = '{16'h0803, 16'hFFFF, 16'h0002, 1'b1};
    vt[4]  = '{16'h1804, 16'h0005, 16'hFFFD, 1'b1};
    vt[5]  = '{16'h4805, 16'h0F0F, 16'h0F0D, 1'b1};
    vt[6]  = '{16'h5806, 16'h3000, 16'h3F0D, 1'b1};
    vt[7]  = '{16'h6807, 16'h00FF, 16'h3FF2, 1'b1};
    vt[8]  = '{16'hF000, 16'h0000, 16'hC00D, 1'b1};
    vt[9]  = '{16'hB000, 16'h0000, 16'hC00C, 1'b0};
    vt[10] = '{16'hFFFF, 16'h0000, 16'hC00C, 1'b0};
    apply_reset("rst3");
    clear_mem('0);
    pac = '0;
    pe  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      logic [DW-1:0] ins;
      ins    = vt[i].instr;
      mem[i] = ins;
      if (!ins[15]) mem[ins[AW-1:0]] = vt[i].opnd;
      push_exp(i, pac, pe);
      pac = vt[i].ac;
      pe  = vt[i].e;
    end
    pulse_start();
    run_prog(3);
    wait_halted("tbl");
    chk("tbl_pc", 32'(pc), 32'd11);
    chk("tbl_ac", 32'(ac), 32'hC00C);

    // skip: instruction fetched from address 2 requests a skip (pc is 3 in EXEC)
    apply_reset("rst4");
    clear_mem('0);
    for (int i = 0; i < 3; i++) mem[i] = 16'hA000;
    mem[3] = 16'hFFFF; mem[4] = 16'hA000; mem[5] = 16'hFFFF;
    skip_pc = 12'd3; skip_en = 1'b1;
    push_exp(0, 16'd0, 1'b0); push_exp(1, 16'd1, 1'b0); push_exp(2, 16'd2, 1'b0);
    push_exp(4, 16'd3, 1'b0); push_exp(5, 16'd4, 1'b0);
    pulse_start();
    run_prog(2);
    wait_halted("skip");
    chk("skip_pc", 32'(pc), 32'd6);
    skip_en = 1'b0;

    // PC wrap: register-reference NOPs (ADD of 0) through the whole space
    apply_reset("rst5");
    clear_mem(16'h8000);
    for (int i = 0; i < 4096; i++) push_exp(i, 16'd0, 1'b0);
    push_exp(0, 16'd0, 1'b0);
    pulse_start();
    run_prog(1);

    // reset while an operand read is outstanding
    apply_reset("rst6");
    clear_mem('0);
    mem[0] = 16'h0123; mem[12'h123] = 16'h7777;
    push_exp(0, 16'd0, 1'b0);
    pulse_start();
    run_prog(1);
    begin
      int budget = 20;
      while (!mem_req && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    chk("mid_oper_req",  32'(mem_req),  32'd1);
    chk("mid_oper_addr", 32'(mem_addr), 32'h123);
    chk("mid_pc",        32'(pc),       32'd1);
    pulse_start();  // ignored while busy
    chk("busy_start_addr", 32'(mem_addr), 32'h123);
    chk("busy_start_busy", 32'(busy),     32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SEQ_TIMEOUT_EN
    // watchdog: no ack ever -> err, HALT after TO request cycles
    clear_mem('0);
    pulse_start();
    begin
      int n = 0;
      for (int c = 0; c < 20; c++) begin
        if (!mem_req) break;
        n++;
        @(negedge clk);
      end
      chk("to_req_cycles", 32'(n), 32'(TO));
    end
    chk("to_err",    32'(err),    32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_pc",     32'(pc),     32'd0);
    mem[0] = 16'hFFFF;
    push_exp(0, 16'd0, 1'b0);
    pulse_start();
    run_prog(1);
    wait_halted("to_restart");
    chk("to_err_sticky", 32'(err), 32'd1);
`else
    // no watchdog: request stays up indefinitely, err stays low
    clear_mem('0);
    pulse_start();
    repeat (10) @(negedge clk);
    chk("nowd_req",  32'(mem_req), 32'd1);
    chk("nowd_busy", 32'(busy),    32'd1);
    chk("nowd_err",  32'(err),     32'd0);
`endif
    apply_reset("rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
